ula_ctrl_sc: RTL and testbench

//  Operation sequencer that drives the 8-bit ULA from the initiator side.
//  - Accepts one instruction per handshake and reads operands from an internal register file.
//  - Issues A/B/SULA to the external combinational ULA, captures its 16-bit result, writes back, updates flags.
//  - Sits between the instruction decoder and ulaProcSc in the single-cycle-ALU datapath.

---
 rtl/ula_pkg.sv | 47 ++++
 rtl/ula_regfile.sv | 40 ++++
 rtl/ula_ctrl_sc.sv | 168 ++++++++++++++++
 tb/tb_ula_ctrl_sc.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared types for the ULA sequencer: opcode and state encodings, flag bit positions
// and the per-opcode carry rule.
package ula_pkg;

  typedef enum logic [3:0] {
    PASS  = 4'd0,
    INC   = 4'd1,
    ADD   = 4'd2,
    ADDC  = 4'd3,
    ADDNB = 4'd4,
    SUB   = 4'd5,
    DEC   = 4'd6,
    MUL   = 4'd7,
    AND   = 4'd8,
    OR    = 4'd9,
    XOR   = 4'd10,
    NOT   = 4'd11,
    SHL   = 4'd12,
    SHR   = 4'd13,
    PASS2 = 4'd14,
    LDI   = 4'd15
  } ula_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    MULHI = 2'd2,
    DONE  = 2'd3
  } ula_state_e;

  // res_flags is packed {N,C,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  // Carry is the ULA's bit 8 for arithmetic/shift ops, "any high bit" for multiply.
  function automatic logic carry_of(input ula_op_e op, input logic [15:0] s);
    logic c;
    case (op)
      INC, ADD, ADDC, ADDNB, SUB, DEC, SHL, SHR: c = s[8];
      MUL:                                        c = |s[15:8];
      default:                                    c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ula_regfile.sv
// NREG x 8-bit register file: one write port, three asynchronous read ports
// (operand A, operand B, debug observation), asynchronous reset to RST_VAL.
module ula_regfile #(
  parameter int         NREG    = 4,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [7:0]              wdata,
  input  logic [$clog2(NREG)-1:0] ra_addr,
  output logic [7:0]              ra_data,
  input  logic [$clog2(NREG)-1:0] rb_addr,
  output logic [7:0]              rb_data,
  input  logic [$clog2(NREG)-1:0] rdbg_addr,
  output logic [7:0]              rdbg_data
);

  logic [7:0] regs_q [NREG];
  logic [7:0] regs_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign ra_data   = regs_q[ra_addr];
  assign rb_data   = regs_q[rb_addr];
  assign rdbg_data = regs_q[rdbg_addr];

endmodule

// File: rtl/ula_ctrl_sc.sv
// Sequencer driving an external combinational 8-bit ULA from a small register file.
// Define ULA_MUL_HI_EN to add the MULHI state that captures the multiply high byte into P.
module ula_ctrl_sc
  import ula_pkg::*;
#(
  parameter int         NREG    = 4,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [3:0]              instr_op,
  input  logic [$clog2(NREG)-1:0] instr_rd,
  input  logic [$clog2(NREG)-1:0] instr_rs,
  input  logic [7:0]              instr_imm,
  output logic [7:0]              ula_a,
  output logic [7:0]              ula_b,
  output logic [3:0]              ula_sula,
  input  logic [15:0]             ula_s,
  output logic                    res_valid,
  output logic [7:0]              res_data,
  output logic [2:0]              res_flags,
  output logic [7:0]              p_hi,
  input  logic [$clog2(NREG)-1:0] dbg_sel,
  output logic [7:0]              dbg_data
);

  localparam int AW = $clog2(NREG);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in IDLE and instr_* are
  // ignored in every other state.
  ula_state_e    state_q, state_d;
  ula_op_e       op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [7:0]    imm_q, imm_d;
  logic [7:0]    ula_a_q, ula_a_d;
  logic [7:0]    ula_b_q, ula_b_d;
  logic [3:0]    ula_sula_q, ula_sula_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [2:0]    res_flags_q, res_flags_d;
  logic [7:0]    rf_a, rf_b, result;
  logic          we;
  ula_op_e       op_in;
`ifdef ULA_MUL_HI_EN
  logic [7:0]    p_q, p_d;
`endif

  ula_regfile #(.NREG(NREG), .RST_VAL(RST_VAL)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (rd_q),
    .wdata     (result),
    .ra_addr   (instr_rd),
    .ra_data   (rf_a),
    .rb_addr   (instr_rs),
    .rb_data   (rf_b),
    .rdbg_addr (dbg_sel),
    .rdbg_data (dbg_data)
  );

  assign op_in  = ula_op_e'(instr_op);
  assign result = (op_q == LDI) ? imm_q : ula_s[7:0];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    ula_a_d     = ula_a_q;
    ula_b_d     = ula_b_q;
    ula_sula_d  = ula_sula_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    we          = 1'b0;
`ifdef ULA_MUL_HI_EN
    p_d         = p_q;
`endif
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          state_d    = EXEC;
          op_d       = op_in;
          rd_d       = instr_rd;
          imm_d      = instr_imm;
          ula_a_d    = rf_a;
          ula_b_d    = rf_b;
          ula_sula_d = (op_in == LDI) ? 4'(PASS) : instr_op;
        end
      end
      EXEC: begin
        we                  = 1'b1;
        res_data_d          = result;
        res_flags_d[FLAG_N] = result[7];
        res_flags_d[FLAG_C] = carry_of(op_q, ula_s);
        res_flags_d[FLAG_Z] = (result == 8'h00);
        state_d             = DONE;
        res_valid_d         = 1'b1;
`ifdef ULA_MUL_HI_EN
        if (op_q == MUL) begin
          state_d     = MULHI;
          res_valid_d = 1'b0;
        end
`endif
      end
      MULHI: begin
        // Operand registers are untouched here so the ULA output stays stable.
`ifdef ULA_MUL_HI_EN
        p_d = ula_s[15:8];
`endif
        state_d     = DONE;
        res_valid_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= PASS;
      rd_q        <= '0;
      imm_q       <= 8'h00;
      ula_a_q     <= 8'h00;
      ula_b_q     <= 8'h00;
      ula_sula_q  <= 4'h0;
      res_valid_q <= 1'b0;
      res_data_q  <= RST_VAL;
      res_flags_q <= 3'b000;
`ifdef ULA_MUL_HI_EN
      p_q         <= RST_VAL;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      ula_a_q     <= ula_a_d;
      ula_b_q     <= ula_b_d;
      ula_sula_q  <= ula_sula_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
`ifdef ULA_MUL_HI_EN
      p_q         <= p_d;
`endif
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign ula_a       = ula_a_q;
  assign ula_b       = ula_b_q;
  assign ula_sula    = ula_sula_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_flags   = res_flags_q;
`ifdef ULA_MUL_HI_EN
  assign p_hi        = p_q;
`else
  assign p_hi        = RST_VAL;
`endif

endmodule

// File: tb/tb_ula_ctrl_sc.sv
// Bench for ula_ctrl_sc: external ULA model, transaction-level reference model,
// per-cycle compare, directed literal cases and randomized instruction stream.
module tb_ula_ctrl_sc;

  localparam int NREG = 4;
`ifdef ULA_MUL_HI_EN
  localparam bit MULHI_EN = 1'b1;
`else
  localparam bit MULHI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  instr_op = 4'd0;
  logic [1:0]  instr_rd = 2'd0;
  logic [1:0]  instr_rs = 2'd0;
  logic [7:0]  instr_imm = 8'h00;
  logic [7:0]  ula_a, ula_b;
  logic [3:0]  ula_sula;
  logic [15:0] ula_s;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [2:0]  res_flags;
  logic [7:0]  p_hi;
  logic [1:0]  dbg_sel = 2'd0;
  logic [7:0]  dbg_data;

  int checks = 0;
  int failures = 0;
  bit en_cmp = 1'b1;
  int dut_done = 0;

  always #5 clk = ~clk;

  ula_ctrl_sc #(.NREG(NREG), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_imm(instr_imm),
    .ula_a(ula_a), .ula_b(ula_b), .ula_sula(ula_sula), .ula_s(ula_s),
    .res_valid(res_valid), .res_data(res_data), .res_flags(res_flags), .p_hi(p_hi),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // External ULA; bits above the defined carry field are filled with junk.
  function automatic logic [15:0] ula_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [7:0] junk;
    logic [8:0] w;
    junk = a ^ {b[3:0], b[7:4]} ^ 8'h5A;
    case (op)
      4'd1:    w = {1'b0, a} + 9'd1;
      4'd2:    w = {1'b0, a} + {1'b0, b};
      4'd3:    w = {1'b0, a} + {1'b0, b} + 9'd1;
      4'd4:    w = {1'b0, a} + {1'b0, ~b};
      4'd5:    w = {1'b0, a} - {1'b0, b};
      4'd6:    w = {1'b0, a} - 9'd1;
      4'd12:   w = {a, 1'b0};
      4'd13:   w = {2'b00, a[7:1]};
      default: w = 9'd0;
    endcase
    case (op)
      4'd0:    return {junk, a};
      4'd7:    return {8'h00, a} * {8'h00, b};
      4'd8:    return {junk, a & b};
      4'd9:    return {junk, a | b};
      4'd10:   return {junk, a ^ b};
      4'd11:   return {junk, ~a};
      4'd14:   return {junk, b};
      4'd15:   return {junk, a};
      default: return {junk[7:1], w};
    endcase
  endfunction

  assign ula_s = ula_fn(ula_a, ula_b, ula_sula);

  function automatic logic [7:0] exp_res(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm);
    logic [15:0] s;
    s = ula_fn(a, b, op);
    return (op == 4'd15) ? imm : s[7:0];
  endfunction

  function automatic logic [2:0] exp_flags(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm);
    logic [15:0] s;
    logic [7:0]  r;
    logic        c;
    s = ula_fn(a, b, op);
    r = exp_res(op, a, b, imm);
    if (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd12, 4'd13}) c = s[8];
    else if (op == 4'd7) c = (int'(a) * int'(b)) > 255;
    else c = 1'b0;
    return {r[7], c, (r == 8'h00)};
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    return (MULHI_EN && op == 4'd7) ? 2 : 1;
  endfunction

  // Reference model: one in-flight instruction, timed in edges since acceptance.
  logic [7:0] m_reg [NREG];
  logic       m_busy, m_valid;
  int         m_k;
  int         acc_cnt = 0;
  logic [3:0] m_op, m_sula;
  logic [1:0] m_rd;
  logic [7:0] m_imm, m_a, m_b, m_data, m_phi;
  logic [2:0] m_flags;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_k <= 0;
      m_op <= 4'd0; m_sula <= 4'd0; m_rd <= 2'd0; m_imm <= 8'h00;
      m_a <= 8'h00; m_b <= 8'h00; m_data <= 8'h00; m_phi <= 8'h00; m_flags <= 3'b000;
      for (int i = 0; i < NREG; i++) m_reg[i] <= 8'h00;
    end else begin
      m_valid <= 1'b0;
      if (!m_busy) begin
        if (instr_valid) begin
          m_busy  <= 1'b1;
          m_k     <= 0;
          m_op    <= instr_op;
          m_rd    <= instr_rd;
          m_imm   <= instr_imm;
          m_a     <= m_reg[instr_rd];
          m_b     <= m_reg[instr_rs];
          m_sula  <= (instr_op == 4'd15) ? 4'd0 : instr_op;
          acc_cnt <= acc_cnt + 1;
        end
      end else begin
        m_k <= m_k + 1;
        if (m_k == 0) begin
          m_reg[m_rd] <= exp_res(m_op, m_a, m_b, m_imm);
          m_data      <= exp_res(m_op, m_a, m_b, m_imm);
          m_flags     <= exp_flags(m_op, m_a, m_b, m_imm);
        end
        if (MULHI_EN && m_op == 4'd7 && m_k == 1) m_phi <= 8'((int'(m_a) * int'(m_b)) >> 8);
        if (m_k + 1 == lat_of(m_op)) m_valid <= 1'b1;
        if (m_k == lat_of(m_op)) m_busy <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (en_cmp) begin
      chk("instr_ready", 16'(instr_ready), 16'(!m_busy));
      chk("res_valid", 16'(res_valid), 16'(m_valid));
      chk("res_data", 16'(res_data), 16'(m_data));
      chk("res_flags", 16'(res_flags), 16'(m_flags));
      chk("p_hi", 16'(p_hi), 16'(m_phi));
      chk("ula_a", 16'(ula_a), 16'(m_a));
      chk("ula_b", 16'(ula_b), 16'(m_b));
      chk("ula_sula", 16'(ula_sula), 16'(m_sula));
      chk("dbg_data", 16'(dbg_data), 16'(m_reg[dbg_sel]));
      if (res_valid === 1'b1) dut_done++;
    end
  end

  task automatic wait_accept(input int start);
    int n = 0;
    while (acc_cnt == start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 16'(acc_cnt == start), 16'd0);
  endtask

  // Issue one instruction; lat = negedges after the accept edge until res_valid is seen.
  task automatic do_op(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [7:0] imm, output int lat);
    int start;
    @(negedge clk); #1;
    start = acc_cnt;
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_imm = imm;
    wait_accept(start);
    #1 instr_valid = 1'b0;
    lat = 1;
    while (res_valid !== 1'b1 && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
  endtask

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int lat, start, d0;
    logic [3:0] seq_op [3];
    logic [1:0] seq_rd [3];
    logic [1:0] seq_rs [3];
    logic [7:0] seq_imm [3];

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 16'(instr_ready), 16'd1);
    chk("rst_res_valid", 16'(res_valid), 16'd0);
    chk("rst_res_data", 16'(res_data), 16'h00);
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = 2'(i);
      #1 chk("rst_reg", 16'(dbg_data), 16'h00);
    end
    @(negedge clk); #1 rst_n = 1'b1;

    // Reset asserted while an instruction is in EXEC
    @(negedge clk); #1;
    start = acc_cnt;
    instr_valid = 1'b1; instr_op = 4'd15; instr_rd = 2'd2; instr_imm = 8'h55;
    wait_accept(start);
    #1 rst_n = 1'b0; instr_valid = 1'b0; dbg_sel = 2'd2;
    #1;
    chk("midrst_ready", 16'(instr_ready), 16'd1);
    chk("midrst_valid", 16'(res_valid), 16'd0);
    chk("midrst_r2", 16'(dbg_data), 16'h00);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("midrst_r2_after", 16'(dbg_data), 16'h00);

    // Directed literal cases
    do_op(4'd15, 2'd0, 2'd0, 8'hF0, lat);
    do_op(4'd15, 2'd1, 2'd0, 8'h20, lat);
    do_op(4'd2, 2'd0, 2'd1, 8'h00, lat);
    chk("add_data", 16'(res_data), 16'h10);
    chk("add_flags", 16'(res_flags), 16'(3'b010));
    chk("add_latency", 16'(lat), 16'd2);
    do_op(4'd5, 2'd1, 2'd1, 8'h00, lat);
    chk("sub_self_data", 16'(res_data), 16'h00);
    chk("sub_self_flags", 16'(res_flags), 16'(3'b001));
    do_op(4'd5, 2'd1, 2'd0, 8'h00, lat);
    chk("sub_borrow_data", 16'(res_data), 16'hF0);
    chk("sub_borrow_flags", 16'(res_flags), 16'(3'b110));
    do_op(4'd15, 2'd1, 2'd0, 8'h20, lat);
    do_op(4'd7, 2'd0, 2'd1, 8'h00, lat);
    chk("mul_data", 16'(res_data), 16'h00);
    chk("mul_flags", 16'(res_flags), 16'(3'b011));
    chk("mul_p_hi", 16'(p_hi), MULHI_EN ? 16'h02 : 16'h00);
    chk("mul_latency", 16'(lat), MULHI_EN ? 16'd3 : 16'd2);
    do_op(4'd15, 2'd2, 2'd0, 8'h81, lat);
    do_op(4'd12, 2'd2, 2'd0, 8'h00, lat);
    chk("shl_data", 16'(res_data), 16'h02);
    chk("shl_flags", 16'(res_flags), 16'(3'b010));
    do_op(4'd15, 2'd3, 2'd0, 8'h81, lat);
    do_op(4'd13, 2'd3, 2'd0, 8'h00, lat);
    chk("shr_data", 16'(res_data), 16'h40);
    chk("shr_flags", 16'(res_flags), 16'(3'b000));

    // Back-to-back with instr_valid held high
    seq_op = '{4'd15, 4'd2, 4'd10};
    seq_rd = '{2'd3, 2'd3, 2'd3};
    seq_rs = '{2'd0, 2'd3, 2'd0};
    seq_imm = '{8'h33, 8'h00, 8'h00};
    @(negedge clk); #1;
    d0 = dut_done;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = acc_cnt;
      instr_op = seq_op[i]; instr_rd = seq_rd[i]; instr_rs = seq_rs[i]; instr_imm = seq_imm[i];
      wait_accept(start);
      #1;
    end
    instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    dbg_sel = 2'd3;
    #1;
    chk("b2b_done_count", 16'(dut_done - d0), 16'd3);
    chk("b2b_r3", 16'(dbg_data), 16'h66);

    // Randomized instruction stream
    repeat (800) begin
      @(negedge clk); #1;
      instr_valid = ($urandom_range(0, 3) != 0);
      instr_op    = 4'($urandom_range(0, 15));
      instr_rd    = 2'($urandom_range(0, 3));
      instr_rs    = 2'($urandom_range(0, 3));
      instr_imm   = 8'($urandom_range(0, 255));
      dbg_sel     = 2'($urandom_range(0, 3));
    end
    instr_valid = 1'b0;
    repeat (6) @(negedge clk);

    en_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
